// File: rtl/depacketizer.sv
// Accepts Ethernet/IPv4/UDP frames addressed to the local endpoint and unpacks the payload into IQ words.
// Define DEPACKETIZER_SEQ_CHECK_EN to build the sequence-gap checker (gap_count/seq_err).
module depacketizer #(
  parameter logic [47:0] LOCAL_MAC  = 48'h021234567890,
  parameter logic [31:0] LOCAL_IP   = 32'h0A000002,
  parameter logic [15:0] LOCAL_PORT = 16'd32179
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dval,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic        rx_err,
  output logic        wr_en,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  output logic [31:0] pkt_count,
  output logic [15:0] drop_count,
  output logic [15:0] ovf_count,
  output logic [63:0] last_seq,
  output logic [15:0] gap_count,
  output logic        seq_err
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;

  localparam logic [10:0] SEQ_FIRST  = 11'h02A;
  localparam logic [10:0] SEQ_LAST   = 11'h031;
  localparam logic [10:0] FRAME_LAST = 11'h5E9;

  state_t      state_q, state_d, cur_state;
  logic [10:0] idx_q, idx_d, cur_idx;
  logic [63:0] seq_q, seq_d;
  logic [23:0] part_q, part_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] ovf_q, ovf_d;
  logic [63:0] last_seq_q, last_seq_d;
  logic [2:0]  seq_lane;
  logic [1:0]  lane;
  logic        drop_inc, good;

  function automatic logic hdr_byte_ok(input logic [10:0] idx, input logic [7:0] b);
    logic ok;
    case (idx)
      11'h000: ok = (b == LOCAL_MAC[47:40]);
      11'h001: ok = (b == LOCAL_MAC[39:32]);
      11'h002: ok = (b == LOCAL_MAC[31:24]);
      11'h003: ok = (b == LOCAL_MAC[23:16]);
      11'h004: ok = (b == LOCAL_MAC[15:8]);
      11'h005: ok = (b == LOCAL_MAC[7:0]);
      11'h00C: ok = (b == 8'h08);
      11'h00D: ok = (b == 8'h00);
      11'h00E: ok = (b == 8'h45);
      11'h017: ok = (b == 8'h11);
      11'h01E: ok = (b == LOCAL_IP[31:24]);
      11'h01F: ok = (b == LOCAL_IP[23:16]);
      11'h020: ok = (b == LOCAL_IP[15:8]);
      11'h021: ok = (b == LOCAL_IP[7:0]);
      11'h024: ok = (b == LOCAL_PORT[15:8]);
      11'h025: ok = (b == LOCAL_PORT[7:0]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    part_d     = part_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    ovf_d      = ovf_q;
    drop_inc   = 1'b0;
    good       = 1'b0;
    cur_idx    = rx_sop ? 11'd0 : idx_q;
    cur_state  = rx_sop ? HDR : state_q;
    seq_lane   = cur_idx[2:0] - 3'd2;
    lane       = cur_idx[1:0] + 2'd2;

    if (rx_dval) begin
      // A new start of frame aborts whatever frame was still open
      if (rx_sop && state_q != IDLE) drop_inc = 1'b1;
      if (cur_state != IDLE) idx_d = cur_idx + 11'd1;

      case (cur_state)
        HDR: begin
          if (cur_idx >= SEQ_FIRST && cur_idx <= SEQ_LAST)
            seq_d[{seq_lane, 3'b000} +: 8] = rx_data;
          if (rx_eop) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else if (!hdr_byte_ok(cur_idx, rx_data)) begin
            state_d = DISCARD;
          end else if (cur_idx == SEQ_LAST) begin
            state_d = PAYLOAD;
          end else begin
            state_d = HDR;
          end
        end
        PAYLOAD: begin
          // Byte lanes cycle I lo, I hi, Q lo, Q hi; the word leaves on the Q hi byte
          case (lane)
            2'd0: part_d[7:0]   = rx_data;
            2'd1: part_d[15:8]  = rx_data;
            2'd2: part_d[23:16] = rx_data;
            default: begin
              if (wr_full) begin
                if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = {part_q[15:0], rx_data, part_q[23:16]};
              end
            end
          endcase
          if (rx_eop) begin
            state_d = IDLE;
            if (cur_idx == FRAME_LAST && !rx_err) good = 1'b1;
            else drop_inc = 1'b1;
          end else if (cur_idx == FRAME_LAST) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
        DISCARD: begin
          if (rx_eop) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pkt_d      = good ? pkt_q + 32'd1 : pkt_q;
    last_seq_d = good ? seq_q : last_seq_q;
    drop_d     = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      part_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      pkt_q      <= '0;
      drop_q     <= '0;
      ovf_q      <= '0;
      last_seq_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      part_q     <= part_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      last_seq_q <= last_seq_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign ovf_count  = ovf_q;
  assign last_seq   = last_seq_q;

`ifdef DEPACKETIZER_SEQ_CHECK_EN
  logic        first_q, first_d;
  logic [15:0] gap_q, gap_d;
  logic        seq_err_q, seq_err_d;

  // The first good frame after reset has no predecessor, so it only arms the checker
  always_comb begin
    first_d   = first_q;
    gap_d     = gap_q;
    seq_err_d = 1'b0;
    if (good) begin
      first_d = 1'b0;
      if (!first_q && seq_q != last_seq_q + 64'd1) begin
        seq_err_d = 1'b1;
        if (gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      gap_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      first_q   <= first_d;
      gap_q     <= gap_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign gap_count = gap_q;
  assign seq_err   = seq_err_q;
`else
  assign gap_count = '0;
  assign seq_err   = 1'b0;
`endif

endmodule

// File: tb/tb_depacketizer.sv
// Randomized scoreboard bench for depacketizer: frames are built from the packet format,
// expected IQ words are queued as bytes are sent, and a monitor pops them on each wr_en.
module tb_depacketizer;
  localparam logic [47:0] MAC  = 48'h021234567890;
  localparam logic [31:0] IP   = 32'h0A000002;
  localparam logic [15:0] PORT = 16'd32179;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_dval, rx_sop, rx_eop, rx_err;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [31:0] pkt_count;
  logic [15:0] drop_count, ovf_count, gap_count;
  logic [63:0] last_seq;
  logic        seq_err;

  always #5 clk = ~clk;

  depacketizer dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_dval(rx_dval), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .pkt_count(pkt_count), .drop_count(drop_count), .ovf_count(ovf_count),
    .last_seq(last_seq), .gap_count(gap_count), .seq_err(seq_err)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int wr_seen = 0;
  int exp_writes = 0;
  int seq_err_seen = 0;
  int exp_seq_err = 0;
  int wr_before;

  // Reference model state
  logic [31:0] m_pkt;
  logic [15:0] m_drop, m_ovf, m_gap;
  logic [63:0] m_last;
  bit          m_in_frame;
`ifdef DEPACKETIZER_SEQ_CHECK_EN
  bit          m_first;
`endif

  logic [7:0]  fbuf [0:1513];
  logic [63:0] cur_seq;
  int          hdr_pos [16] = '{0, 1, 2, 3, 4, 5, 12, 13, 14, 23, 30, 31, 32, 33, 36, 37};
  int          kind, pos, flen;
  logic [63:0] s;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", wr_data);
        end else begin
          checkOutput("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
        end
      end
      if (seq_err) seq_err_seen++;
    end
  end

  task automatic idleCycle();
    @(posedge clk); #1;
    rx_dval = 1'b0;
    rx_data = 8'($urandom);
    rx_sop  = 1'($urandom);
    rx_eop  = 1'($urandom);
    rx_err  = 1'($urandom);
    wr_full = 1'($urandom);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit sop, input bit eop, input bit err, input bit full);
    while ($urandom_range(0, 5) == 0) idleCycle();
    @(posedge clk); #1;
    rx_dval = 1'b1;
    rx_data = d;
    rx_sop  = sop;
    rx_eop  = eop;
    rx_err  = err;
    wr_full = full;
  endtask

  task automatic modelReset();
    m_pkt = '0; m_drop = '0; m_ovf = '0; m_gap = '0; m_last = '0;
    m_in_frame = 1'b0;
`ifdef DEPACKETIZER_SEQ_CHECK_EN
    m_first = 1'b1;
`endif
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic modelGood();
    m_pkt = m_pkt + 32'd1;
`ifdef DEPACKETIZER_SEQ_CHECK_EN
    if (!m_first && cur_seq != m_last + 64'd1) begin
      m_gap = sat16(m_gap);
      exp_seq_err++;
    end
    m_first = 1'b0;
`endif
    m_last = cur_seq;
  endtask

  // Valid Ethernet/IPv4/UDP frame to the local endpoint; samples either I=n,Q=0x8000+n or random
  task automatic buildFrame(input logic [63:0] seq, input bit rand_samples);
    logic [15:0] iv, qv;
    for (int i = 0; i < 1514; i++) fbuf[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) fbuf[i] = MAC[8*(5-i) +: 8];
    fbuf[12] = 8'h08; fbuf[13] = 8'h00; fbuf[14] = 8'h45; fbuf[23] = 8'h11;
    for (int i = 0; i < 4; i++) fbuf[30+i] = IP[8*(3-i) +: 8];
    fbuf[36] = PORT[15:8]; fbuf[37] = PORT[7:0];
    for (int i = 0; i < 8; i++) fbuf[42+i] = seq[8*i +: 8];
    if (!rand_samples) begin
      for (int n = 0; n < 366; n++) begin
        iv = 16'(n);
        qv = 16'h8000 + 16'(n);
        fbuf[50+4*n]   = iv[7:0];
        fbuf[50+4*n+1] = iv[15:8];
        fbuf[50+4*n+2] = qv[7:0];
        fbuf[50+4*n+3] = qv[15:8];
      end
    end
    cur_seq = seq;
  endtask

  task automatic sendFrame(input int len, input bit with_eop, input bit err, input bit hdr_good,
                           input int full_lo, input int full_hi, input bit rand_full);
    bit full;
    int w;
    if (m_in_frame) m_drop = sat16(m_drop);
    m_in_frame = 1'b1;
    for (int i = 0; i < len; i++) begin
      full = 1'($urandom);
      if (i >= 50 && ((i - 50) % 4) == 3) begin
        w = (i - 50) / 4;
        full = (w >= full_lo && w <= full_hi) || (rand_full && $urandom_range(0, 3) == 0);
        if (hdr_good) begin
          if (full) m_ovf = sat16(m_ovf);
          else begin
            exp_q.push_back({fbuf[i-2], fbuf[i-3], fbuf[i], fbuf[i-1]});
            exp_writes++;
          end
        end
      end
      applyStimulus(fbuf[i], i == 0, with_eop && i == len - 1,
                    (i == len - 1) ? err : 1'($urandom), full);
    end
    if (with_eop) begin
      m_in_frame = 1'b0;
      if (hdr_good && len == 1514 && !err) modelGood();
      else m_drop = sat16(m_drop);
    end
    idleCycle();
  endtask

  task automatic settle();
    repeat (4) idleCycle();
    checkOutput("pkt_count", 64'(pkt_count), 64'(m_pkt));
    checkOutput("drop_count", 64'(drop_count), 64'(m_drop));
    checkOutput("ovf_count", 64'(ovf_count), 64'(m_ovf));
    checkOutput("last_seq", last_seq, m_last);
    checkOutput("gap_count", 64'(gap_count), 64'(m_gap));
    checkOutput("seq_err_pulses", 64'(seq_err_seen), 64'(exp_seq_err));
    checkOutput("pending_words", 64'(exp_q.size()), 64'd0);
    checkOutput("total_writes", 64'(wr_seen), 64'(exp_writes));
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rx_dval = 1'b0;
    rst = 1'b1;
    modelReset();
    exp_q.delete();
    #1;
    checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count), 64'd0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
    checkOutput("rst_ovf_count", 64'(ovf_count), 64'd0);
    checkOutput("rst_last_seq", last_seq, 64'd0);
    checkOutput("rst_gap_count", 64'(gap_count), 64'd0);
    checkOutput("rst_seq_err", 64'(seq_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx_data = '0; rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; wr_full = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    doReset();

    $display("[TB] good frame, counting samples");
    wr_before = wr_seen;
    buildFrame(64'd0, 1'b0);
    sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
    settle();
    checkOutput("good_frame_writes", 64'(wr_seen - wr_before), 64'd366);

    $display("[TB] wrong destination MAC");
    wr_before = wr_seen;
    buildFrame(64'd1, 1'b0);
    fbuf[5] = 8'h91;
    sendFrame(1514, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
    settle();
    checkOutput("bad_mac_writes", 64'(wr_seen - wr_before), 64'd0);

    $display("[TB] rx_err on final byte");
    wr_before = wr_seen;
    buildFrame(64'd2, 1'b1);
    sendFrame(1514, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
    settle();
    checkOutput("err_frame_writes", 64'(wr_seen - wr_before), 64'd366);

    $display("[TB] FIFO full on words 10-12");
    wr_before = wr_seen;
    buildFrame(64'd1, 1'b1);
    sendFrame(1514, 1'b1, 1'b0, 1'b1, 10, 12, 1'b0);
    settle();
    checkOutput("full_frame_writes", 64'(wr_seen - wr_before), 64'd363);

    $display("[TB] sequence 5, 6, 9 after reset");
    doReset();
    buildFrame(64'd5, 1'b1); sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1); settle();
    buildFrame(64'd6, 1'b1); sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1); settle();
    buildFrame(64'd9, 1'b1); sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1); settle();

    $display("[TB] random frames");
    for (int k = 0; k < 8; k++) begin
      kind = $urandom_range(0, 4);
      s = ($urandom_range(0, 1) == 1) ? m_last + 64'd1 : {$urandom, $urandom};
      buildFrame(s, 1'b1);
      case (kind)
        0: sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);
        1: begin
          pos = hdr_pos[$urandom_range(0, 15)];
          fbuf[pos] = fbuf[pos] ^ 8'($urandom_range(1, 255));
          sendFrame(1514, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1);
        end
        2: begin
          flen = $urandom_range(20, 1513);
          sendFrame(flen, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);
        end
        3: sendFrame(1514, 1'b1, 1'b1, 1'b1, -1, -1, 1'b1);
        default: begin
          flen = $urandom_range(20, 1513);
          sendFrame(flen, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        end
      endcase
      if (kind != 4) settle();
    end
    buildFrame(m_last + 64'd1, 1'b1);
    sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);
    settle();

    $display("[TB] reset during payload, then seq 7");
    buildFrame(64'd3, 1'b0);
    sendFrame(200, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    repeat (2) idleCycle();
    checkOutput("words_before_reset", 64'(exp_q.size()), 64'd0);
    doReset();
    for (int i = 0; i < 30; i++) applyStimulus(8'($urandom), 1'b0, i == 29, 1'b0, 1'b0);
    idleCycle();
    settle();
    buildFrame(64'd7, 1'b0);
    sendFrame(1514, 1'b1, 1'b0, 1'b1, -1, -1, 1'b0);
    settle();
    checkOutput("post_reset_pkt_count", 64'(pkt_count), 64'd1);
    checkOutput("post_reset_last_seq", last_seq, 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depacketizer.md
DEPACKETIZER -- requirements
Module: depacketizer

Interface
REQ-001 Parameters SHALL be: LOCAL_MAC (48'h021234567890, accepted destination MAC); LOCAL_IP (32'h0A000002, accepted destination IP); LOCAL_PORT (16'd32179, accepted UDP destination port).
REQ-002 Port clk, input, 1: single clock for all logic; reset is asynchronous and active-high.
REQ-003 Port rst, input, 1: asynchronous active-high reset.
REQ-004 Port rx_data, input, 8: MAC receive byte.
REQ-005 Port rx_dval, input, 1: rx_data/rx_sop/rx_eop/rx_err valid this cycle.
REQ-006 Ports rx_sop, rx_eop, rx_err, input, 1 each: first byte, last byte, and frame error (rx_err is sampled with rx_eop).
REQ-007 Port wr_en, output, 1: write strobe to the sample FIFO.
REQ-008 Port wr_data, output, 32: IQ word; I in [31:16], Q in [15:0].
REQ-009 Port wr_full, input, 1: sample FIFO full.
REQ-010 Status outputs: pkt_count (32), drop_count (16), ovf_count (16), last_seq (64), gap_count (16), seq_err (1).

Function
REQ-011 Byte index SHALL reset to 0 on each valid rx_sop and SHALL increment once per rx_dval byte; frame length is 1514 bytes (indices 0x000-0x5E9).
REQ-012 The FSM SHALL have states IDLE, HDR, PAYLOAD and DISCARD; a valid rx_sop in any state SHALL enter HDR at index 0.
REQ-013 HDR checks, all required, else go to DISCARD:
- bytes 0x00-0x05 = LOCAL_MAC
- bytes 0x0C-0x0D = 0x0800
- byte 0x0E = 0x45
- byte 0x17 = 0x11
- bytes 0x1E-0x21 = LOCAL_IP
- bytes 0x24-0x25 = LOCAL_PORT
REQ-014 Bytes 0x2A-0x31 SHALL be captured little-endian (byte 0x2A is LSB) as the frame sequence number; after byte 0x31 the FSM SHALL enter PAYLOAD.
REQ-015 Payload bytes 0x32-0x5E9 SHALL repeat the order I[7:0], I[15:8], Q[7:0], Q[15:8]; wr_en SHALL pulse for 1 cycle, 1 cycle after each Q[15:8] byte, with the assembled word on wr_data (366 words per frame).
REQ-016 If wr_full is high when a word would be written, that word SHALL be dropped, wr_en SHALL stay low, and ovf_count SHALL increment, saturating at 0xFFFF.
REQ-017 A frame is good only when rx_eop arrives at index 0x5E9 with rx_err=0 in PAYLOAD; then pkt_count++ (wraps) and last_seq SHALL take the captured sequence number, 1 cycle after rx_eop.
REQ-018 Each of the following SHALL increment drop_count (saturating) and return the FSM to IDLE:
- rx_eop in HDR/DISCARD
- rx_eop at the wrong index
- rx_eop with rx_err=1
- rx_sop before rx_eop
- index passing 0x5E9 without rx_eop
REQ-019 Words already written from a frame later dropped SHALL NOT be retracted; header failure SHALL cause zero writes for that frame.
REQ-020 DISCARD SHALL ignore bytes until rx_eop or rx_sop; bytes with rx_dval=0 SHALL be ignored in every state.

Reset
REQ-021 Asserting rst SHALL immediately clear:
- FSM to IDLE and index to 0
- wr_en, wr_data and seq_err to 0
- all counters and last_seq to 0
- first-packet flag to 1
REQ-022 A frame in progress when rst asserts SHALL be abandoned without counting; after release, bytes SHALL be ignored until the next rx_sop.

Configuration
REQ-023 With macro DEPACKETIZER_SEQ_CHECK_EN defined, on each good frame that is not the first, a sequence number != last_seq+1 (64-bit wrap) SHALL increment gap_count (saturating) and pulse seq_err for 1 cycle together with the last_seq update; the first good frame after reset only clears the first-packet flag.
REQ-024 With DEPACKETIZER_SEQ_CHECK_EN undefined, gap_count and seq_err SHALL be constant 0 and no comparator logic SHALL be built.

Verification
REQ-025 Good frame: seq 0, samples I=n, Q=0x8000+n for n=0..365 -> 366 wr_en pulses, wr_data 0x00008000..0x016D816D, pkt_count=1, last_seq=0.
REQ-026 Frame with destination MAC 02:12:34:56:78:91 -> zero writes, drop_count=1, pkt_count=0.
REQ-027 Good frame, rx_eop at index 0x5E9 with rx_err=1 -> 366 writes, drop_count=1, pkt_count unchanged.
REQ-028 wr_full held high for words 10-12 of a good frame -> 363 writes, ovf_count=3, pkt_count=1.
REQ-029 With the macro: good frames with seq 5, 6, then 9 -> gap_count=1 with one seq_err pulse on the third frame, last_seq=9; without the macro, gap_count stays 0.
REQ-030 rst asserted at payload byte 200 and released, then a good frame with seq 7 -> counters 0 before the new frame; afterwards pkt_count=1 and last_seq=7.
